// File: rtl/pacman_ctrl.sv
// Pac-Man movement/life controller: per-frame turn and move probes against a maze
// oracle, horizontal tunnel wrap, mouth animation, death timing and respawn.
module pacman_ctrl #(
    parameter logic [8:0] START_X      = 9'd112,
    parameter logic [8:0] START_Y      = 9'd188,
    parameter logic [8:0] X_MIN        = 9'd7,
    parameter logic [8:0] X_MAX        = 9'd216,
    parameter int         SPEED_DIV    = 2,
    parameter int         ANIM_DIV     = 4,
    parameter int         DEATH_FRAMES = 60,
    parameter logic [1:0] LIVES        = 2'd3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic [1:0] dir_req,
    input  logic       dir_req_valid,
    input  logic       ghost_hit,
    output logic [8:0] probe_x,
    output logic [8:0] probe_y,
    output logic [1:0] probe_dir,
    input  logic       probe_blocked,
    output logic [8:0] xloc,
    output logic [8:0] yloc,
    output logic [1:0] pacman_dir,
    output logic       pacman_alive,
    output logic [1:0] animation_cycle,
    output logic [1:0] lives,
    output logic       game_over
);

    localparam int SW = $clog2(SPEED_DIV + 1);
    localparam int AW = $clog2(ANIM_DIV + 1);
    localparam int DW = $clog2(DEATH_FRAMES + 1);
    localparam logic [SW-1:0] SPEED_LAST = SW'(SPEED_DIV - 1);
    localparam logic [AW-1:0] ANIM_LAST  = AW'(ANIM_DIV - 1);
    localparam logic [DW-1:0] DEATH_LAST = DW'(DEATH_FRAMES - 1);

    typedef enum logic [2:0] {
        WAIT, PROBE_TURN, PROBE_MOVE, DYING, RESPAWN, OVER
    } state_t;

    state_t        r_state, w_state_next;
    logic [8:0]    r_xloc, r_yloc;
    logic [1:0]    r_pacman_dir, r_anim_cycle, r_lives;
    logic          r_alive, r_game_over;
    logic          r_pend_valid;
    logic [1:0]    r_pend_dir;
    logic [SW-1:0] r_speed_cnt;
    logic [AW-1:0] r_anim_cnt;
    logic [DW-1:0] r_death_cnt;

    logic       w_hit, w_adopt, w_step;
    logic [1:0] w_probe_dir;
    logic [8:0] w_step_x, w_step_y;

    assign w_hit = ghost_hit && (r_state == WAIT || r_state == PROBE_TURN || r_state == PROBE_MOVE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= WAIT;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_probe_dir  = r_pacman_dir;
        w_adopt      = 1'b0;
        w_step       = 1'b0;
        case (r_state)
            WAIT: begin
                if (ghost_hit)       w_state_next = DYING;
                else if (frame_tick) w_state_next = r_pend_valid ? PROBE_TURN : PROBE_MOVE;
            end
            PROBE_TURN: begin
                w_probe_dir = r_pend_dir;
                if (ghost_hit) begin
                    w_state_next = DYING;
                end else begin
                    w_adopt      = !probe_blocked;
                    w_state_next = PROBE_MOVE;
                end
            end
            PROBE_MOVE: begin
                if (ghost_hit) begin
                    w_state_next = DYING;
                end else begin
                    w_step       = 1'b1;
                    w_state_next = WAIT;
                end
            end
            DYING: begin
                if (frame_tick && r_death_cnt == DEATH_LAST)
                    w_state_next = (r_lives == 2'd0) ? OVER : RESPAWN;
            end
            RESPAWN: w_state_next = WAIT;
            OVER:    w_state_next = OVER;
            default: w_state_next = WAIT;
        endcase
    end

    // Neighbour pixel in the probed direction; also the next center when moving.
    always_comb begin
        w_step_x = r_xloc;
        w_step_y = r_yloc;
        case (w_probe_dir)
            2'b00: w_step_x = (r_xloc == X_MAX) ? X_MIN : r_xloc + 9'd1;
            2'b01: w_step_y = (r_yloc == 9'd0) ? 9'd0 : r_yloc - 9'd1;
            2'b10: w_step_y = (r_yloc == 9'h1FF) ? r_yloc : r_yloc + 9'd1;
            default: w_step_x = (r_xloc == X_MIN || r_xloc == 9'd0) ? X_MAX : r_xloc - 9'd1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_xloc       <= START_X;
            r_yloc       <= START_Y;
            r_pacman_dir <= 2'b00;
            r_anim_cycle <= 2'd0;
            r_lives      <= LIVES;
            r_alive      <= 1'b1;
            r_game_over  <= 1'b0;
            r_pend_valid <= 1'b0;
            r_pend_dir   <= 2'b00;
            r_speed_cnt  <= '0;
            r_anim_cnt   <= '0;
            r_death_cnt  <= '0;
        end else begin
            // Pending request: death entry and respawn win over a same-cycle load.
            if (w_hit || r_state == RESPAWN) begin
                r_pend_valid <= 1'b0;
            end else if (dir_req_valid && r_state != DYING && r_state != OVER) begin
                r_pend_valid <= 1'b1;
                r_pend_dir   <= dir_req;
            end else if (w_adopt) begin
                r_pend_valid <= 1'b0;
            end

            if (w_adopt) r_pacman_dir <= r_pend_dir;

            if (w_step) begin
                r_speed_cnt <= (r_speed_cnt == SPEED_LAST) ? '0 : r_speed_cnt + 1'b1;
                if (!probe_blocked) begin
                    if (r_speed_cnt == SPEED_LAST) begin
                        r_xloc <= w_step_x;
                        r_yloc <= w_step_y;
                    end
                    if (r_anim_cnt == ANIM_LAST) begin
                        r_anim_cnt   <= '0;
                        r_anim_cycle <= r_anim_cycle + 2'd1;
                    end else begin
                        r_anim_cnt <= r_anim_cnt + 1'b1;
                    end
                end
            end

            if (w_hit) begin
                r_lives     <= (r_lives == 2'd0) ? 2'd0 : r_lives - 2'd1;
                r_alive     <= 1'b0;
                r_death_cnt <= '0;
            end else if (r_state == DYING && frame_tick) begin
                r_death_cnt <= (r_death_cnt == DEATH_LAST) ? '0 : r_death_cnt + 1'b1;
            end

            if (r_state == RESPAWN) begin
                r_xloc       <= START_X;
                r_yloc       <= START_Y;
                r_pacman_dir <= 2'b00;
                r_anim_cycle <= 2'd0;
                r_speed_cnt  <= '0;
                r_anim_cnt   <= '0;
                r_alive      <= 1'b1;
            end

            if (r_state == DYING && w_state_next == OVER) r_game_over <= 1'b1;
        end
    end

    assign probe_dir       = w_probe_dir;
    assign probe_x         = w_step_x;
    assign probe_y         = w_step_y;
    assign xloc            = r_xloc;
    assign yloc            = r_yloc;
    assign pacman_dir      = r_pacman_dir;
    assign pacman_alive    = r_alive;
    assign animation_cycle = r_anim_cycle;
    assign lives           = r_lives;
    assign game_over       = r_game_over;

endmodule

// File: tb/tb_pacman_ctrl.sv
// Directed self-checking bench for pacman_ctrl: movement, turns, tunnel wrap,
// deaths, game over and asynchronous reset.
module tb_pacman_ctrl;

    logic       clk;
    logic       rst_n;
    logic       frame_tick;
    logic [1:0] dir_req;
    logic       dir_req_valid;
    logic       ghost_hit;
    logic [8:0] probe_x, probe_y;
    logic [1:0] probe_dir;
    logic       probe_blocked;
    logic [8:0] xloc, yloc;
    logic [1:0] pacman_dir;
    logic       pacman_alive;
    logic [1:0] animation_cycle;
    logic [1:0] lives;
    logic       game_over;

    logic wall_all;
    logic wall_up;
    int   n_tests;
    int   n_fail;

    pacman_ctrl dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .frame_tick      (frame_tick),
        .dir_req         (dir_req),
        .dir_req_valid   (dir_req_valid),
        .ghost_hit       (ghost_hit),
        .probe_x         (probe_x),
        .probe_y         (probe_y),
        .probe_dir       (probe_dir),
        .probe_blocked   (probe_blocked),
        .xloc            (xloc),
        .yloc            (yloc),
        .pacman_dir      (pacman_dir),
        .pacman_alive    (pacman_alive),
        .animation_cycle (animation_cycle),
        .lives           (lives),
        .game_over       (game_over)
    );

    // Maze model: optionally everything is a wall, or only the pixel above.
    assign probe_blocked = wall_all || (wall_up && probe_dir == 2'b01);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic frame();
        @(negedge clk) frame_tick = 1'b1;
        @(negedge clk) frame_tick = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic req(input logic [1:0] d);
        @(negedge clk);
        dir_req       = d;
        dir_req_valid = 1'b1;
        @(negedge clk) dir_req_valid = 1'b0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n = 1'b0; frame_tick = 1'b0; dir_req = 2'b00; dir_req_valid = 1'b0;
        ghost_hit = 1'b0; wall_all = 1'b0; wall_up = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        check("rst_xloc", int'(xloc), 112);
        check("rst_yloc", int'(yloc), 188);
        check("rst_dir", int'(pacman_dir), 0);
        check("rst_alive", int'(pacman_alive), 1);
        check("rst_anim", int'(animation_cycle), 0);
        check("rst_lives", int'(lives), 3);
        check("rst_over", int'(game_over), 0);
        check("rst_probe_x", int'(probe_x), 113);
        check("rst_probe_y", int'(probe_y), 188);

        repeat (4) frame();
        check("run4_xloc", int'(xloc), 114);
        check("run4_yloc", int'(yloc), 188);
        check("run4_dir", int'(pacman_dir), 0);
        check("run4_anim", int'(animation_cycle), 1);

        // Turn up refused by a wall; pending request survives to the next frame.
        wall_up = 1'b1;
        req(2'b01);
        frame();
        check("turn_blk_dir", int'(pacman_dir), 0);
        check("turn_blk_xloc", int'(xloc), 114);
        wall_up = 1'b0;
        frame();
        check("turn_ok_dir", int'(pacman_dir), 1);
        check("turn_ok_yloc", int'(yloc), 187);
        check("probe_up_y", int'(probe_y), 186);

        wall_all = 1'b1;
        frame();
        frame();
        check("blk_yloc", int'(yloc), 187);
        check("blk_anim", int'(animation_cycle), 1);
        wall_all = 1'b0;

        // Head left to the tunnel edge and wrap.
        req(2'b11);
        frame();
        check("left_dir", int'(pacman_dir), 3);
        check("left_xloc", int'(xloc), 114);
        for (int n = 0; n < 300 && xloc != 9'd7; n++) frame();
        check("edge_xloc", int'(xloc), 7);
        check("edge_probe_x", int'(probe_x), 216);
        frame();
        check("wrap_hold_xloc", int'(xloc), 7);
        frame();
        check("wrap_xloc", int'(xloc), 216);
        check("wrap_yloc", int'(yloc), 187);

        // Death coincident with a frame tick: no move.
        @(negedge clk);
        frame_tick = 1'b1;
        ghost_hit  = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        ghost_hit  = 1'b0;
        check("die1_xloc", int'(xloc), 216);
        check("die1_lives", int'(lives), 2);
        check("die1_alive", int'(pacman_alive), 0);
        ghost_hit = 1'b1;
        repeat (3) @(negedge clk);
        ghost_hit = 1'b0;
        check("dying_ignore_hit", int'(lives), 2);
        repeat (59) frame();
        check("dying59_alive", int'(pacman_alive), 0);
        frame();
        check("resp_xloc", int'(xloc), 112);
        check("resp_yloc", int'(yloc), 188);
        check("resp_alive", int'(pacman_alive), 1);
        check("resp_dir", int'(pacman_dir), 0);
        check("resp_anim", int'(animation_cycle), 0);

        for (int d = 0; d < 2; d++) begin
            @(negedge clk) ghost_hit = 1'b1;
            @(negedge clk) ghost_hit = 1'b0;
            repeat (60) frame();
            check("death_lives", int'(lives), 1 - d);
        end
        check("over_flag", int'(game_over), 1);
        check("over_alive", int'(pacman_alive), 0);
        req(2'b10);
        repeat (5) frame();
        check("over_xloc", int'(xloc), 112);
        check("over_dir", int'(pacman_dir), 0);
        check("over_lives", int'(lives), 0);
        check("over_sticky", int'(game_over), 1);

        // Reset takes effect without a clock edge.
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("arst_over", int'(game_over), 0);
        check("arst_lives", int'(lives), 3);
        check("arst_alive", int'(pacman_alive), 1);
        @(negedge clk) rst_n = 1'b1;

        // Reset in mid-probe must drop the pending request.
        @(negedge clk);
        dir_req       = 2'b11;
        dir_req_valid = 1'b1;
        frame_tick    = 1'b1;
        @(negedge clk);
        dir_req_valid = 1'b0;
        frame_tick    = 1'b0;
        #1 rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        frame();
        check("midrst_dir", int'(pacman_dir), 0);
        check("midrst_xloc", int'(xloc), 112);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
